// File: rtl/rdecode_wb_if.sv
// Decode/write-back stage bundle: D-register fields, forwarding sources, W-stage
// write-back and the decoded d_* operands handed to the E pipeline register.
interface rdecode_wb_if #(
  parameter int DATA_W = 64
);
  logic [1:0]        D_stat;
  logic [3:0]        D_icode;
  logic [3:0]        D_ifun;
  logic [3:0]        D_rA;
  logic [3:0]        D_rB;
  logic [DATA_W-1:0] D_valC;
  logic [DATA_W-1:0] D_valP;

  logic [3:0]        e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] m_valM;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;

  logic [1:0]        d_stat;
  logic [3:0]        d_icode;
  logic [3:0]        d_ifun;
  logic [DATA_W-1:0] d_valC;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  logic [3:0]        d_dstE;
  logic [3:0]        d_dstM;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;

  // Decode stage side: consumes pipeline state, produces the d_* operands.
  modport master (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
    input  W_dstE, W_dstM, W_valE, W_valM,
    output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
    output d_dstE, d_dstM, d_srcA, d_srcB
  );

  // Surrounding pipeline side: supplies pipeline state, captures d_* operands.
  modport slave (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
    output W_dstE, W_dstM, W_valE, W_valM,
    input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
    input  d_dstE, d_dstM, d_srcA, d_srcB
  );
endinterface

// File: rtl/rdecode_wb.sv
// Y86-64 decode/write-back: register decode, operand forwarding, 15-entry register file.
// Zero-latency combinational outputs; no flow control, stalls belong to pipeline control.
module rdecode_wb #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input logic         clk,
  input logic         rst,
  rdecode_wb_if.master bus
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam int         NREGS    = 15;

  logic [DATA_W-1:0] regs_q [0:NREGS-1];
  logic [DATA_W-1:0] regs_d [0:NREGS-1];

  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;

  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;

    case (bus.D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.D_rA;
      I_RET, I_POPQ:                      src_a = REG_RSP;
      default:                            src_a = REG_NONE;
    endcase

    case (bus.D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = bus.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = REG_RSP;
      default:                            src_b = REG_NONE;
    endcase

    case (bus.D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = bus.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = REG_RSP;
      default:                            dst_e = REG_NONE;
    endcase

    case (bus.D_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = bus.D_rA;
      default:                            dst_m = REG_NONE;
    endcase
  end

  // Index 0xF has no storage, so a NONE source reads as zero.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i)) rf_a = regs_q[i];
      if (src_b == 4'(i)) rf_b = regs_q[i];
    end
  end

  // Youngest producer first; the NONE guard keeps an idle stage from matching.
  always_comb begin
    val_a = rf_a;
    if (bus.D_icode == I_CALL || bus.D_icode == I_JXX) val_a = bus.D_valP;
    else if (src_a == REG_NONE)                        val_a = '0;
    else if (src_a == bus.e_dstE)                      val_a = bus.e_valE;
    else if (src_a == bus.M_dstM)                      val_a = bus.m_valM;
    else if (src_a == bus.M_dstE)                      val_a = bus.M_valE;
    else if (src_a == bus.W_dstM)                      val_a = bus.W_valM;
    else if (src_a == bus.W_dstE)                      val_a = bus.W_valE;
  end

  always_comb begin
    val_b = rf_b;
    if (src_b == REG_NONE)          val_b = '0;
    else if (src_b == bus.e_dstE)   val_b = bus.e_valE;
    else if (src_b == bus.M_dstM)   val_b = bus.m_valM;
    else if (src_b == bus.M_dstE)   val_b = bus.M_valE;
    else if (src_b == bus.W_dstM)   val_b = bus.W_valM;
    else if (src_b == bus.W_dstE)   val_b = bus.W_valE;
  end

  // M write applied after E so a popq %rsp leaves the loaded value in %rsp.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.W_dstE == 4'(i)) regs_d[i] = bus.W_valE;
      if (bus.W_dstM == 4'(i)) regs_d[i] = bus.W_valM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 4) ? RSP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.d_stat  = bus.D_stat;
  assign bus.d_icode = bus.D_icode;
  assign bus.d_ifun  = bus.D_ifun;
  assign bus.d_valC  = bus.D_valC;
  assign bus.d_valA  = val_a;
  assign bus.d_valB  = val_b;
  assign bus.d_srcA  = src_a;
  assign bus.d_srcB  = src_b;
  assign bus.d_dstE  = dst_e;
  assign bus.d_dstM  = dst_m;

endmodule

// File: doc/rdecode_wb.md
Name: rdecode_wb

Overview:
- Decode/write-back stage of the Y86-64 pipeline: the producer side of the decode-to-execute interface.
- Decodes D-register fields into d_srcA/d_srcB/d_dstE/d_dstM and resolves d_valA/d_valB via forwarding.
- Owns the 15-entry register file, written at the clock edge from the W-stage results.
- All d_* outputs are captured by the E pipeline register on the next rising edge.

Parameters:
- DATA_W, 64, register/data width.
- RSP_RESET, 0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- D_stat  input  2  D-register status.
- D_icode, D_ifun  input  4 each  D-register instruction code/function.
- D_rA, D_rB  input  4 each  register specifiers (0xF = none).
- D_valC, D_valP  input  DATA_W each  constant, next PC.
- e_dstE  input  4  execute-stage destination (already Cnd-qualified).
- e_valE  input  DATA_W  execute-stage ALU result.
- M_dstE, M_dstM  input  4 each  memory-stage destinations.
- M_valE  input  DATA_W  memory-stage ALU result.
- m_valM  input  DATA_W  memory-stage read data.
- W_dstE, W_dstM  input  4 each  write-back destinations.
- W_valE, W_valM  input  DATA_W each  write-back data.
- d_stat, d_icode, d_ifun  output  2/4/4  pass-through of D_stat/D_icode/D_ifun.
- d_valC  output  DATA_W  pass-through of D_valC.
- d_valA, d_valB  output  DATA_W each  resolved operands.
- d_dstE, d_dstM, d_srcA, d_srcB  output  4 each  decoded register IDs.

Behaviour:
- icode map: 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq. RSP = 4, NONE = 0xF.
- d_srcA: rA for {2,4,6,A}; RSP for {9,B}; else NONE.
- d_srcB: rB for {4,5,6}; RSP for {8,9,A,B}; else NONE.
- d_dstE: rB for {2,3,6}; RSP for {8,9,A,B}; else NONE.
- d_dstM: rA for {5,B}; else NONE.
- Decode, select and forwarding are purely combinational; the stage adds zero latency.
- d_valA priority, first match wins:
  1. D_icode in {7,8} -> D_valP.
  2. d_srcA == e_dstE -> e_valE.
  3. == M_dstM -> m_valM.
  4. == M_dstE -> M_valE.
  5. == W_dstM -> W_valM.
  6. == W_dstE -> W_valE.
  7. Otherwise register file.
- d_valB: same chain without step 1.
- NONE never matches any destination. A source of NONE yields 0.
- Register file: 15 x DATA_W, indices 0..14, async read.
  - On posedge clk: if W_dstE != NONE, write W_valE; if W_dstM != NONE, write W_valM.
  - Same register in both: W_valM wins (popq %rsp semantics).
- Read of a register being written in the same cycle returns the new value via W forwarding, never the stale array value.
- Reset (async): all registers = 0 except reg 4 = RSP_RESET. Reset takes effect immediately, including mid-write.
- While rst = 1, no writes occur. Combinational outputs remain live during reset and reflect the reset array.
- Forwarding is a single-cycle path. Load-use stalls are owned by pipeline control, not this block.

Test Plan:
1. Assert rst mid-cycle with W_dstE=3, W_valE=5 -> every read returns 0 (reg 4 = RSP_RESET); no write to reg 3 after release.
2. W_dstE=2, W_valE=0x11, one edge; then D_icode=6, D_rA=2, D_rB=0xF, no in-flight dst -> d_srcA=2, d_valA=0x11, d_srcB=0xF, d_valB=0, d_dstE=0xF.
3. D_icode=6, rA=1, rB=1; e_dstE=1/e_valE=0xA, M_dstM=1/m_valM=0xB, W_dstE=1/W_valE=0xC -> d_valA = d_valB = 0xA. Drop e_dstE to 0xF -> both 0xB.
4. D_icode=8, D_valP=0x40, e_dstE=4 -> d_valA=0x40, d_srcB=4, d_valB=e_valE, d_dstE=4.
5. W_dstE=4/W_valE=0x100 and W_dstM=4/W_valM=0x200, one edge -> reg 4 reads 0x200. The same-cycle decode of srcA=4 also returns 0x200 via W forwarding.
6. D_icode=B (popq), rA=7 -> d_srcA=4, d_srcB=4, d_dstE=4, d_dstM=7. D_icode=1 -> all four IDs 0xF, d_valA=d_valB=0.
